// File: rtl/control_votacion_pkg.sv
// rtl/control_votacion_pkg.sv - shared state encodings, defaults and width helper for the election sequencer
package control_votacion_pkg;

   // FSM state encodings
   localparam logic [1:0] S_REPOSO   = 2'd0;
   localparam logic [1:0] S_VOTACION = 2'd1;
   localparam logic [1:0] S_CONTEO   = 2'd2;

   // Default parameter values
   localparam int N_DEF      = 5;
   localparam int UMBRAL_DEF = 3;
   localparam int TMAX_DEF   = 200;
   localparam int TW_DEF     = 8;

   // Bits needed to hold a count of 0..n ones
   function automatic int ancho_cuenta(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/control_votacion_contador_unos.sv
// rtl/control_votacion_contador_unos.sv - combinational popcount of an N-bit vector
module contador_unos
   import control_votacion_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = ancho_cuenta(N)
) (
   input  logic [N-1:0] vec_i,
   output logic [W-1:0] cuenta_o
);

   // Sum every bit of the input vector
   always_comb begin
      cuenta_o = '0;
      for (int i = 0; i < N; i++) begin
         cuenta_o = cuenta_o + W'(vec_i[i]);
      end
   end

endmodule

// File: rtl/control_votacion.sv
// rtl/control_votacion.sv - timed N-voter majority election sequencer
module control_votacion
   import control_votacion_pkg::*;
#(
   parameter int N      = N_DEF,
   parameter int UMBRAL = UMBRAL_DEF,
   parameter int TMAX   = TMAX_DEF,
   parameter int TW     = TW_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inicio,
   input  logic [N-1:0] emitido,
   input  logic [N-1:0] voto,
   output logic         v,
   output logic         fin,
   output logic         ocupado,
   output logic [N-1:0] votados,
   output logic         expirado
);

   localparam int            CW       = ancho_cuenta(N);
   localparam logic [CW-1:0] UMBRAL_C = CW'(UMBRAL);
   localparam logic [TW-1:0] TMAX_M1  = TW'(TMAX - 1);
   localparam logic [N-1:0]  TODOS    = '1;

   logic [1:0]    estado_q,   estado_d;
   logic [TW-1:0] cnt_q,      cnt_d;
   logic [N-1:0]  votos_q,    votos_d;
   logic [N-1:0]  votados_q,  votados_d;
   logic          v_q,        v_d;
   logic          fin_q,      fin_d;
   logic          ocupado_q,  ocupado_d;
   logic          expirado_q, expirado_d;

   logic [N-1:0]  acept;
   logic [CW-1:0] unos;

   contador_unos #(
      .N (N),
      .W (CW)
   ) u_contador (
      .vec_i    (votos_q),
      .cuenta_o (unos)
   );

   // Next-state logic: start, vote collection with first-vote-wins, close and count
   always_comb begin
      estado_d   = estado_q;
      cnt_d      = cnt_q;
      votos_d    = votos_q;
      votados_d  = votados_q;
      v_d        = v_q;
      fin_d      = 1'b0;
      ocupado_d  = ocupado_q;
      expirado_d = expirado_q;
      acept      = '0;

      case (estado_q)
         S_REPOSO: begin
            ocupado_d = 1'b0;
            if (inicio) begin
               estado_d   = S_VOTACION;
               ocupado_d  = 1'b1;
               votados_d  = '0;
               votos_d    = '0;
               cnt_d      = '0;
               v_d        = 1'b0;
               expirado_d = 1'b0;
            end
         end
         S_VOTACION: begin
            // Only voters not yet marked may vote; the vote register bit is still 0 for them
            acept     = emitido & ~votados_q;
            votados_d = votados_q | acept;
            votos_d   = votos_q | (voto & acept);
            cnt_d     = cnt_q + TW'(1);
            // A complete roll call wins over a simultaneous timeout
            if (votados_d == TODOS) begin
               estado_d = S_CONTEO;
            end else if (cnt_q == TMAX_M1) begin
               estado_d   = S_CONTEO;
               expirado_d = 1'b1;
            end
         end
         S_CONTEO: begin
            v_d       = (unos >= UMBRAL_C);
            fin_d     = 1'b1;
            ocupado_d = 1'b0;
            estado_d  = S_REPOSO;
         end
         default: begin
            estado_d  = S_REPOSO;
            ocupado_d = 1'b0;
         end
      endcase
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q   <= S_REPOSO;
         cnt_q      <= '0;
         votos_q    <= '0;
         votados_q  <= '0;
         v_q        <= 1'b0;
         fin_q      <= 1'b0;
         ocupado_q  <= 1'b0;
         expirado_q <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         cnt_q      <= cnt_d;
         votos_q    <= votos_d;
         votados_q  <= votados_d;
         v_q        <= v_d;
         fin_q      <= fin_d;
         ocupado_q  <= ocupado_d;
         expirado_q <= expirado_d;
      end
   end

   assign v        = v_q;
   assign fin      = fin_q;
   assign ocupado  = ocupado_q;
   assign votados  = votados_q;
   assign expirado = expirado_q;

endmodule

// File: tb/tb_control_votacion.sv
// tb/tb_control_votacion.sv - scoreboard bench for the election sequencer
module tb_control_votacion;

   localparam int N    = 5;
   localparam int TMAX = 10;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         inicio = 1'b0;
   logic [N-1:0] emitido = '0;
   logic [N-1:0] voto = '0;
   logic         v, fin, ocupado, expirado;
   logic [N-1:0] votados;

   typedef struct {
      logic         v;
      logic         e;
      logic [N-1:0] vot;
      int           cyc;
   } esperado_t;

   esperado_t cola[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   control_votacion #(
      .N      (N),
      .UMBRAL (3),
      .TMAX   (TMAX),
      .TW     (8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .inicio   (inicio),
      .emitido  (emitido),
      .voto     (voto),
      .v        (v),
      .fin      (fin),
      .ocupado  (ocupado),
      .votados  (votados),
      .expirado (expirado)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nombre, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic arranca();
      inicio = 1'b1;
      tick();
      inicio = 1'b0;
   endtask

   task automatic vota(input logic [N-1:0] m, input logic [N-1:0] val);
      emitido = m;
      voto    = val;
      tick();
      emitido = '0;
      voto    = '0;
   endtask

   task automatic espera(input logic ev, input logic ee, input logic [N-1:0] evot, input int ecyc);
      esperado_t x;
      x.v = ev; x.e = ee; x.vot = evot; x.cyc = ecyc;
      cola.push_back(x);
   endtask

   // Monitor: every fin pulse is matched against the oldest expected result
   always @(negedge clk) begin
      if (fin === 1'b1) begin
         if (cola.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_fin: fin=1 with no election pending (cycle %0d)", cyc);
         end else begin
            esperado_t x;
            x = cola.pop_front();
            chk("fin_cycle", cyc, x.cyc);
            chk("v", v, x.v);
            chk("expirado", expirado, x.e);
            chk("votados", votados, x.vot);
            chk("ocupado_at_fin", ocupado, 1'b0);
         end
      end
   end

   initial begin
      int s;
      // Reset state
      idle(2);
      reset = 1'b0;
      chk("rst_ocupado", ocupado, 1'b0);
      chk("rst_votados", votados, 5'b0);
      chk("rst_v", v, 1'b0);
      chk("rst_fin", fin, 1'b0);
      chk("rst_expirado", expirado, 1'b0);

      // Reset in the middle of an election
      arranca();
      chk("mid_ocupado", ocupado, 1'b1);
      vota(5'b00001, 5'b00001);
      vota(5'b00010, 5'b00010);
      chk("mid_votados", votados, 5'b00011);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_ocupado", ocupado, 1'b0);
      chk("midrst_votados", votados, 5'b0);
      chk("midrst_v", v, 1'b0);
      idle(4);

      // Full election, votes 1,0,1,1,0 on separate cycles
      arranca();
      vota(5'b00001, 5'b00001);
      vota(5'b00010, 5'b00000);
      vota(5'b00100, 5'b00100);
      vota(5'b01000, 5'b01000);
      vota(5'b10000, 5'b00000);
      espera(1'b1, 1'b0, 5'b11111, cyc + 1);
      idle(4);
      chk("hold_votados", votados, 5'b11111);
      chk("hold_v", v, 1'b1);
      chk("hold_ocupado", ocupado, 1'b0);

      // Simultaneous strobes then a repeated strobe from voter 2
      arranca();
      vota(5'b11111, 5'b00011);
      espera(1'b0, 1'b0, 5'b11111, cyc + 1);
      vota(5'b00100, 5'b00100);
      idle(3);

      // Timeout with only voters 0..2 voting 1
      arranca();
      s = cyc;
      vota(5'b00001, 5'b00001);
      vota(5'b00010, 5'b00010);
      vota(5'b00100, 5'b00100);
      espera(1'b1, 1'b1, 5'b00111, s + TMAX + 1);
      idle(TMAX + 2);

      // Last vote lands on the timeout edge: completion wins
      arranca();
      s = cyc;
      vota(5'b00001, 5'b00001);
      vota(5'b00010, 5'b00010);
      vota(5'b00100, 5'b00000);
      vota(5'b01000, 5'b00000);
      idle(TMAX - 5);
      vota(5'b10000, 5'b10000);
      chk("late_vote_edge", cyc, s + TMAX);
      espera(1'b1, 1'b0, 5'b11111, s + TMAX + 1);
      idle(3);

      // inicio held high through the election and over the fin-fall edge
      inicio = 1'b1;
      tick();
      vota(5'b00001, 5'b00001);
      chk("inicio_no_restart", votados, 5'b00001);
      vota(5'b11110, 5'b11110);
      espera(1'b1, 1'b0, 5'b11111, cyc + 1);
      tick();
      tick();
      chk("b2b_ocupado", ocupado, 1'b1);
      chk("b2b_votados", votados, 5'b0);
      chk("b2b_v", v, 1'b0);
      chk("b2b_fin", fin, 1'b0);
      inicio = 1'b0;
      vota(5'b11111, 5'b00000);
      espera(1'b0, 1'b0, 5'b11111, cyc + 1);
      idle(3);

      // Every vote pattern as a complete single-edge election
      for (int p = 0; p < 32; p++) begin
         logic [N-1:0] pat;
         pat = N'(p);
         arranca();
         vota(5'b11111, pat);
         espera($countones(pat) >= 3, 1'b0, 5'b11111, cyc + 1);
         idle(2);
      end

      // Drain: every expected result must have been seen
      for (int k = 0; k < 20 && cola.size() != 0; k++) tick();
      checks++;
      if (cola.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results never seen, expected 0", cola.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
